aes_key_sched_ctrl: RTL and testbench
=====================================

AES_KEY_SCHED_CTRL -- requirements
Module: aes_key_sched_ctrl

Interface
REQ-001 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request to expand key_in; sampled only in IDLE.
REQ-005 key_in  input  128  AES-128 cipher key, bit order [0:127], word0 = [0:31].
REQ-006 sw_in  output  32  RotWord(w3) of current key register = {w3[8:31], w3[0:7]}, driven to the external S-box.
REQ-007 sw_out  input  32  external S-box result for sw_in; the S-box SHALL be combinational with zero latency.
REQ-008 busy  output  1  high while an expansion is in progress.
REQ-009 rk_valid  output  1  rk_out/rk_round valid this cycle.
REQ-010 rk_round  output  4  round index 0..10 of rk_out.
REQ-011 rk_out  output  128  round key, same bit order as key_in.
REQ-012 done  output  1  one-cycle pulse with the round-10 key.

Function
REQ-013 The FSM SHALL have states IDLE, EXPAND and DONE.
REQ-014 In IDLE with start=1 at edge T, the block SHALL latch key_in and enter EXPAND.
REQ-015 In the cycle after T, it SHALL present rk_out=key_in, rk_round=0 and rk_valid=1.
REQ-016 Each following cycle r=1..10 SHALL present round key r with rk_valid=1, one key per cycle, giving a fixed latency of T+1+r.
REQ-017 Round key r SHALL be computed as follows: w0'=w0^sw_out^{rcon(r),24'h0}; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
REQ-018 rcon(1..10) SHALL be 01,02,04,08,10,20,40,80,1B,36, generated internally from the round counter; any other index SHALL yield 00.
REQ-019 The round counter SHALL be 4 bits and count 0..10, never wrapping.
REQ-020 busy SHALL be 1 from cycle T+1 through T+11 inclusive.
REQ-021 done SHALL be 1 only in cycle T+11, coincident with rk_round=10; the FSM SHALL then pass through DONE and return to IDLE, so the next start is accepted at T+12.
REQ-022 start while busy=1 SHALL be ignored, with no effect on the sequence.
REQ-023 key_in changes after T SHALL not affect the expansion.
REQ-024 When rk_valid=0, rk_out and rk_round SHALL hold their last values.

Reset
REQ-025 rst=1 SHALL force IDLE, round counter=0, busy=0, rk_valid=0, done=0, rk_round=0, rk_out=0 and the key register=0.
REQ-026 rst SHALL take priority over start and over an expansion in progress; an aborted sequence SHALL produce no further rk_valid or done.
REQ-027 While in reset or IDLE, sw_in SHALL reflect the cleared or last key register and SHALL have no side effects.

Configuration
REQ-028 With macro AES_KEY_STORE_EN defined, the block SHALL add port rd_idx (input, 4) and port rd_key (output, 128), plus an 11-entry x 128-bit key store.
REQ-029 With AES_KEY_STORE_EN, each rk_valid cycle SHALL write rk_out into entry rk_round.
REQ-030 With AES_KEY_STORE_EN, rd_key SHALL return entry rd_idx combinationally; rd_idx greater than 10 SHALL return 0.
REQ-031 With AES_KEY_STORE_EN, reset SHALL clear all entries to 0.
REQ-032 Without AES_KEY_STORE_EN, those ports and the store SHALL be absent and behaviour SHALL be streaming-only.

Verification
REQ-033 Scenario: key 2b7e151628aed2a6abf7158809cf4f3c, start pulse -> round1 a0fafe1788542cb123a339392a6c7605, round10 d014f9a8c9ee2589e13f0cc8b6630ca6, done at T+11, busy for 11 cycles.
REQ-034 Scenario: all-zero key -> round1 62636363626363636263636362636363, rcon sequence matches REQ-018 across rounds 1..10.
REQ-035 Scenario: start re-pulsed at T+3 and T+7 -> sequence unchanged, exactly one done.
REQ-036 Scenario: rst at T+5 -> next cycle busy=0, rk_valid=0; no done follows; a fresh start then produces a full, correct 11-key sequence.
REQ-037 Scenario: back-to-back starts held high -> second sequence rk_round=0 at T+13, no overlap with the first.
REQ-038 Scenario (AES_KEY_STORE_EN): after the REQ-033 run, rd_idx=0 -> key_in, rd_idx=10 -> d014f9a8..., rd_idx=15 -> 0.

Source files
------------

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key schedule controller: streams round keys 0..10, one per cycle, using an external S-box.
// Optional macro AES_KEY_STORE_EN adds an 11-entry round-key store with a combinational read port.
module aes_key_sched_ctrl (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key_in,
   output logic [31:0]  sw_in,
   input  logic [31:0]  sw_out,
   output logic         busy,
   output logic         rk_valid,
   output logic [3:0]   rk_round,
   output logic [127:0] rk_out,
   output logic         done
`ifdef AES_KEY_STORE_EN
   ,
   input  logic [3:0]   rd_idx,
   output logic [127:0] rd_key
`endif
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] EXPAND = 2'd1;
   localparam logic [1:0] DONE   = 2'd2;

   localparam logic [3:0] LAST_ROUND = 4'd10;

   logic [1:0]   state;
   logic [3:0]   round_cnt;
   logic [127:0] key_reg;

   logic [3:0]   next_round;
   logic [31:0]  w0, w1, w2, w3;
   logic [31:0]  n0, n1, n2, n3;

   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    rcon = 8'h01;
         4'd2:    rcon = 8'h02;
         4'd3:    rcon = 8'h04;
         4'd4:    rcon = 8'h08;
         4'd5:    rcon = 8'h10;
         4'd6:    rcon = 8'h20;
         4'd7:    rcon = 8'h40;
         4'd8:    rcon = 8'h80;
         4'd9:    rcon = 8'h1b;
         4'd10:   rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   endfunction

   // Word 0 (bit 0 in the big-endian key numbering) sits in the most significant 32 bits.
   assign w0 = key_reg[127:96];
   assign w1 = key_reg[95:64];
   assign w2 = key_reg[63:32];
   assign w3 = key_reg[31:0];

   assign sw_in      = {w3[23:0], w3[31:24]};
   assign next_round = round_cnt + 4'd1;

   assign n0 = w0 ^ sw_out ^ {rcon(next_round), 24'h000000};
   assign n1 = w1 ^ n0;
   assign n2 = w2 ^ n1;
   assign n3 = w3 ^ n2;

   // The key register doubles as the round-key output, so it holds its value whenever idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         round_cnt <= 4'd0;
         key_reg   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  key_reg   <= key_in;
                  round_cnt <= 4'd0;
                  state     <= EXPAND;
               end
            end
            EXPAND: begin
               key_reg   <= {n0, n1, n2, n3};
               round_cnt <= next_round;
               if (next_round == LAST_ROUND) begin
                  state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // DONE is the cycle that presents round 10, so it still counts as a valid busy cycle.
   assign busy     = (state != IDLE);
   assign rk_valid = busy;
   assign done     = (state == DONE);
   assign rk_out   = key_reg;
   assign rk_round = round_cnt;

`ifdef AES_KEY_STORE_EN
   logic [127:0] key_store [0:10];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 11; i++) begin
            key_store[i] <= '0;
         end
      end else if (rk_valid && (rk_round <= LAST_ROUND)) begin
         key_store[rk_round] <= rk_out;
      end
   end

   always_comb begin
      rd_key = '0;
      if (rd_idx <= LAST_ROUND) begin
         rd_key = key_store[rd_idx];
      end
   end
`endif

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Scoreboard bench for aes_key_sched_ctrl: a FIPS-197 style key expansion model feeds an expected queue,
// a negedge monitor pops and compares. Store checks are included when AES_KEY_STORE_EN is defined.
module tb_aes_key_sched_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [127:0] key_in;
   logic [31:0]  sw_in;
   logic [31:0]  sw_out;
   logic         busy;
   logic         rk_valid;
   logic [3:0]   rk_round;
   logic [127:0] rk_out;
   logic         done;
`ifdef AES_KEY_STORE_EN
   logic [3:0]   rd_idx;
   logic [127:0] rd_key;
`endif

   aes_key_sched_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .key_in   (key_in),
      .sw_in    (sw_in),
      .sw_out   (sw_out),
      .busy     (busy),
      .rk_valid (rk_valid),
      .rk_round (rk_round),
      .rk_out   (rk_out),
      .done     (done)
`ifdef AES_KEY_STORE_EN
      ,
      .rd_idx   (rd_idx),
      .rd_key   (rd_key)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int           cyc;
      logic [3:0]   rnd;
      logic [127:0] key;
   } exp_t;

   exp_t         expQ[$];
   bit           resetCyc[int];
   int           r0Cyc[$];
   int           cyc = 0;
   int           nextAccept = 0;
   int           checks = 0;
   int           fails = 0;
   int           doneCount = 0;
   int           busyCycles = 0;
   bit           monEn = 1'b0;
   logic [7:0]   sbox [256];
   logic [127:0] modelKeys [11];
   logic [127:0] obsKey [11];
   int           obsCyc [11];
   logic [127:0] holdKey = '0;
   logic [3:0]   holdRound = '0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p = 8'h00; aa = a; bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [31:0] subWord(input logic [31:0] w);
      return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
   endfunction

   assign sw_out = subWord(sw_in);

   task automatic buildSbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] b;
         b = 8'h00;
         if (x != 0) begin
            for (int y = 1; y < 256; y++) begin
               if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
            end
         end
         sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
      end
   endtask

   // Textbook 44-word expansion; round key r is words 4r..4r+3.
   task automatic expandModel(input logic [127:0] k);
      logic [31:0] w [44];
      logic [31:0] temp;
      logic [7:0]  rc;
      w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         temp = w[i-1];
         if (i % 4 == 0) begin
            temp = subWord({temp[23:0], temp[31:24]}) ^ {rc, 24'h000000};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end
         w[i] = w[i-4] ^ temp;
      end
      for (int r = 0; r < 11; r++) begin
         modelKeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      end
   endtask

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Models the effect of the coming clock edge, then drives it.
   task automatic applyStimulus(input logic s, input logic r, input logic [127:0] k);
      int e;
      start  = s;
      rst    = r;
      key_in = k;
      e = cyc + 1;
      if (r) begin
         while (expQ.size() > 0 && expQ[$].cyc >= e) void'(expQ.pop_back());
         resetCyc[e] = 1'b1;
         nextAccept = e + 1;
      end else if (s && e >= nextAccept) begin
         expandModel(k);
         for (int i = 0; i < 11; i++) begin
            exp_t x;
            x.cyc = e + i; x.rnd = 4'(i); x.key = modelKeys[i];
            expQ.push_back(x);
         end
         nextAccept = e + 12;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic waitIdle(input int budget);
      int n;
      n = 0;
      while (expQ.size() > 0 && n < budget) begin
         applyStimulus(1'b0, 1'b0, key_in);
         n++;
      end
      if (expQ.size() > 0) begin
         checkOutput("drain_timeout", 128'(expQ.size()), 128'd0);
         expQ.delete();
      end
      applyStimulus(1'b0, 1'b0, key_in);
      applyStimulus(1'b0, 1'b0, key_in);
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (monEn) begin
         if (resetCyc.exists(cyc)) begin
            holdKey = '0;
            holdRound = '0;
         end
         while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
            checkOutput("rk_missing_at_cycle", 128'(cyc), 128'(expQ[0].cyc));
            void'(expQ.pop_front());
         end
         if (expQ.size() > 0 && expQ[0].cyc == cyc) begin
            e = expQ.pop_front();
            checkOutput("rk_valid", 128'(rk_valid), 128'd1);
            checkOutput("busy_valid", 128'(busy), 128'd1);
            checkOutput("rk_round", 128'(rk_round), 128'(e.rnd));
            checkOutput("rk_out", rk_out, e.key);
            checkOutput("done", 128'(done), 128'(e.rnd == 4'd10));
            holdKey = e.key;
            holdRound = e.rnd;
            obsKey[e.rnd] = rk_out;
            obsCyc[e.rnd] = cyc;
         end else begin
            checkOutput("rk_valid_idle", 128'(rk_valid), 128'd0);
            checkOutput("busy_idle", 128'(busy), 128'd0);
            checkOutput("done_idle", 128'(done), 128'd0);
            checkOutput("rk_out_hold", rk_out, holdKey);
            checkOutput("rk_round_hold", 128'(rk_round), 128'(holdRound));
         end
         if (rk_valid && rk_round == 4'd0) r0Cyc.push_back(cyc);
         if (done) doneCount++;
         if (busy) busyCycles++;
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [127:0] k;
      logic [31:0]  derived;
      logic [7:0]   rconTab [10];
      int           doneBase, busyBase;

      rconTab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
      rst = 1'b1; start = 1'b0; key_in = '0;
`ifdef AES_KEY_STORE_EN
      rd_idx = 4'd0;
`endif
      buildSbox();

      applyStimulus(1'b1, 1'b1, rand128());
      monEn = 1'b1;
      applyStimulus(1'b1, 1'b1, rand128());
      applyStimulus(1'b0, 1'b1, '0);
      checkOutput("reset_busy", 128'(busy), 128'd0);
      checkOutput("reset_rk_valid", 128'(rk_valid), 128'd0);
      checkOutput("reset_done", 128'(done), 128'd0);
      checkOutput("reset_rk_round", 128'(rk_round), 128'd0);
      checkOutput("reset_rk_out", rk_out, 128'd0);
      applyStimulus(1'b0, 1'b0, '0);

      // Reference vector.
      $display("[TB] scenario: reference key");
      k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      doneBase = doneCount; busyBase = busyCycles;
      applyStimulus(1'b1, 1'b0, k);
      waitIdle(40);
      checkOutput("ref_round0", obsKey[0], k);
      checkOutput("ref_round1", obsKey[1], 128'ha0fafe1788542cb123a339392a6c7605);
      checkOutput("ref_round10", obsKey[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      checkOutput("ref_latency", 128'(obsCyc[10] - obsCyc[0]), 128'd10);
      checkOutput("ref_done_count", 128'(doneCount - doneBase), 128'd1);
      checkOutput("ref_busy_cycles", 128'(busyCycles - busyBase), 128'd11);
`ifdef AES_KEY_STORE_EN
      rd_idx = 4'd0;  #1 checkOutput("store_idx0", rd_key, k);
      rd_idx = 4'd10; #1 checkOutput("store_idx10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      rd_idx = 4'd15; #1 checkOutput("store_idx15", rd_key, 128'd0);
      rd_idx = 4'(11 + $urandom_range(0, 3)); #1 checkOutput("store_idx_oob", rd_key, 128'd0);
      rd_idx = 4'd1;  #1 checkOutput("store_idx1", rd_key, 128'ha0fafe1788542cb123a339392a6c7605);
`endif

      // All-zero key and the round constant sequence.
      $display("[TB] scenario: zero key");
      applyStimulus(1'b1, 1'b0, '0);
      waitIdle(40);
      checkOutput("zero_round1", obsKey[1], 128'h62636363626363636263636362636363);
      for (int r = 1; r <= 10; r++) begin
         derived = obsKey[r][127:96] ^ obsKey[r-1][127:96] ^
                   subWord({obsKey[r-1][23:0], obsKey[r-1][31:24]});
         checkOutput($sformatf("rcon_round%0d", r), 128'(derived), 128'({rconTab[r-1], 24'h000000}));
      end

      // Re-pulsing start mid-expansion.
      $display("[TB] scenario: start re-pulse");
      doneBase = doneCount;
      applyStimulus(1'b1, 1'b0, rand128());
      for (int i = 1; i <= 8; i++) begin
         applyStimulus((i == 3) || (i == 7), 1'b0, rand128());
      end
      waitIdle(40);
      checkOutput("repulse_done_count", 128'(doneCount - doneBase), 128'd1);

      // Reset abort then a fresh run.
      $display("[TB] scenario: reset abort");
      doneBase = doneCount;
      applyStimulus(1'b1, 1'b0, rand128());
      for (int i = 1; i <= 4; i++) applyStimulus(1'b0, 1'b0, key_in);
      applyStimulus(1'b0, 1'b1, key_in);
      checkOutput("abort_busy", 128'(busy), 128'd0);
      checkOutput("abort_rk_valid", 128'(rk_valid), 128'd0);
      for (int i = 0; i < 14; i++) applyStimulus(1'b0, 1'b0, key_in);
      checkOutput("abort_no_done", 128'(doneCount - doneBase), 128'd0);
      applyStimulus(1'b1, 1'b0, rand128());
      waitIdle(40);
      checkOutput("abort_fresh_done", 128'(doneCount - doneBase), 128'd1);

      // Start held high: runs go back to back without overlap.
      $display("[TB] scenario: start held high");
      r0Cyc.delete();
      for (int i = 0; i < 30; i++) applyStimulus(1'b1, 1'b0, rand128());
      waitIdle(40);
      checkOutput("held_two_runs", 128'(r0Cyc.size() >= 2), 128'd1);
      if (r0Cyc.size() >= 2) begin
         checkOutput("held_restart_gap", 128'(r0Cyc[1] - r0Cyc[0]), 128'd12);
      end

      // Random keys, stray starts, changing key_in and one mid-run reset.
      $display("[TB] scenario: random");
      for (int it = 0; it < 6; it++) begin
         int len;
         applyStimulus(1'b1, 1'b0, rand128());
         len = $urandom_range(8, 16);
         for (int j = 0; j < len; j++) begin
            applyStimulus(($urandom % 5) == 0, (it == 3) && (j == 4), rand128());
         end
         waitIdle(40);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
